// File: rtl/exercise_stim_chk.sv
// exercise_stim_chk
// -----------------
// Stimulus and response checker for one exercise module. It sends a run of
// LFSR-derived vectors to the exercise and compares the aligned exercise
// output with a golden reference output. At the end of the run it reports
// the mismatch count, the index of the first failing vector and a pass flag.
//
// Optional feature, selected by the macro EXERCISE_STIM_CHK_ERR_STOP_EN:
//   defined   -> the first mismatch ends the run on the next edge.
//   undefined -> every run completes and every mismatch is counted.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high
//   start          in   single-cycle run request (accepted in IDLE or DONE)
//   stim           out  registered stimulus vector (DATA_W)
//   stim_valid     out  stim holds a new vector this cycle
//   dut_out        in   exercise output, aligned DUT_LAT cycles after stim
//   ref_out        in   golden output, same alignment as dut_out
//   busy           out  run or drain in progress
//   done           out  run complete, results stable
//   pass           out  done and err_cnt == 0
//   err_cnt        out  mismatch count, saturates at 16'hFFFF
//   first_err_idx  out  index of the first mismatching vector, 16'hFFFF if none
//   dbg_state      out  current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: the stimulus side has no back-pressure. A vector is transferred
// in every cycle where stim_valid is high. The response for that vector must
// be present on dut_out/ref_out exactly DUT_LAT cycles later.
module exercise_stim_chk #(
    parameter int          DATA_W      = 8,
    parameter int          OUT_W       = 8,
    parameter int          NUM_VECTORS = 256,
    parameter int          DUT_LAT     = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [DATA_W-1:0] stim,
    output logic              stim_valid,
    input  logic [OUT_W-1:0]  dut_out,
    input  logic [OUT_W-1:0]  ref_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [15:0]       first_err_idx,
    output logic [1:0]        dbg_state
);

`ifdef EXERCISE_STIM_CHK_ERR_STOP_EN
    localparam bit ERR_STOP = 1'b1;
`else
    localparam bit ERR_STOP = 1'b0;
`endif

    // With a combinational exercise there is still one drain cycle, so the
    // pipe and the drain counter are always at least one entry deep.
    localparam int          PIPE_D     = (DUT_LAT > 0) ? DUT_LAT : 1;
    localparam logic [1:0]  DRAIN_LAST = 2'(PIPE_D - 1);
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [15:0]                    lfsr_q, lfsr_d;
    logic [DATA_W-1:0]              stim_q, stim_d;
    logic [15:0]                    vec_idx_q, vec_idx_d;
    logic [1:0]                     drain_cnt_q, drain_cnt_d;
    logic [PIPE_D-1:0]              pv_q, pv_d;
    logic [PIPE_D-1:0][15:0]        pidx_q, pidx_d;
    logic [15:0]                    err_cnt_q, err_cnt_d;
    logic [15:0]                    first_err_q, first_err_d;

    logic [15:0] lfsr_nxt;
    logic        in_run;
    logic        cmp_valid;
    logic [15:0] cmp_idx;
    logic        mismatch;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        stim_d      = stim_q;
        vec_idx_d   = vec_idx_q;
        drain_cnt_d = drain_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;

        lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        in_run   = (state_q == S_RUN);

        // Valid/index delay line that follows each vector to its compare cycle.
        pv_d      = pv_q;
        pidx_d    = pidx_q;
        pv_d[0]   = in_run;
        pidx_d[0] = vec_idx_q;
        for (int i = 1; i < PIPE_D; i++) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end

        cmp_valid = (DUT_LAT == 0) ? in_run    : pv_q[PIPE_D-1];
        cmp_idx   = (DUT_LAT == 0) ? vec_idx_q : pidx_q[PIPE_D-1];

        // Only compare while busy. This drops leftover pipe entries after an
        // early stop and any stale entries seen in IDLE or DONE.
        mismatch = cmp_valid && (state_q == S_RUN || state_q == S_DRAIN) &&
                   (dut_out != ref_out);

        if (mismatch) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            // Vector indices stop at 16'hFFFE, so 16'hFFFF can mark "no error yet".
            if (first_err_q == 16'hFFFF) begin
                first_err_d = cmp_idx;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    lfsr_d      = SEED_EFF;
                    stim_d      = SEED_EFF[DATA_W-1:0];
                    vec_idx_d   = 16'd0;
                    err_cnt_d   = 16'd0;
                    first_err_d = 16'hFFFF;
                    pv_d        = '0;
                end
            end
            S_RUN: begin
                if (vec_idx_q == LAST_IDX) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 2'd0;
                end else begin
                    vec_idx_d = vec_idx_q + 16'd1;
                    lfsr_d    = lfsr_nxt;
                    stim_d    = lfsr_nxt[DATA_W-1:0];
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ERR_STOP && mismatch) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED_EFF;
            stim_q      <= '0;
            vec_idx_q   <= 16'd0;
            drain_cnt_q <= 2'd0;
            pv_q        <= '0;
            pidx_q      <= '0;
            err_cnt_q   <= 16'd0;
            first_err_q <= 16'hFFFF;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            stim_q      <= stim_d;
            vec_idx_q   <= vec_idx_d;
            drain_cnt_q <= drain_cnt_d;
            pv_q        <= pv_d;
            pidx_q      <= pidx_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign stim          = stim_q;
    assign stim_valid    = (state_q == S_RUN);
    assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign pass          = (state_q == S_DONE) && (err_cnt_q == 16'd0);
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_exercise_stim_chk.sv
module tb_exercise_stim_chk;

`ifdef EXERCISE_STIM_CHK_ERR_STOP_EN
  localparam bit ERR_STOP = 1'b1;
`else
  localparam bit ERR_STOP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Exercise model used on all instances: nibble swap, then XOR 8'h5A.
  function automatic logic [7:0] ex_f(input logic [7:0] s);
    return {s[3:0], s[7:4]} ^ 8'h5A;
  endfunction

  // LFSR stepping rule, used to build the expected stimulus stream.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // ---------------- instance A: 16 vectors, latency 2 ----------------
  logic       a_start = 1'b0;
  logic [7:0] a_stim, a_ref, a_dut;
  logic       a_valid, a_busy, a_done, a_pass;
  logic [15:0] a_err, a_first;
  logic [1:0] a_dbg;
  logic [7:0] a_p1, a_p2;
  logic       a_v1, a_v2;
  int         a_cnt, a_i1, a_i2;
  bit         a_bad [16];

  always @(posedge clk) begin
    if (rst || a_start) a_cnt <= 0;
    else if (a_valid) a_cnt <= a_cnt + 1;
    a_p1 <= a_stim; a_p2 <= a_p1;
    a_v1 <= a_valid; a_v2 <= a_v1;
    a_i1 <= a_cnt; a_i2 <= a_i1;
  end
  assign a_ref = ex_f(a_p2);
  assign a_dut = a_ref ^ ((a_v2 && a_bad[a_i2 & 15]) ? 8'h80 : 8'h00);

  exercise_stim_chk #(.DATA_W(8), .OUT_W(8), .NUM_VECTORS(16), .DUT_LAT(2)) u_a (
    .clk(clk), .reset(rst), .start(a_start), .stim(a_stim), .stim_valid(a_valid),
    .dut_out(a_dut), .ref_out(a_ref), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_cnt(a_err), .first_err_idx(a_first), .dbg_state(a_dbg));

  // ---------------- instance C: 16 vectors, latency 1 ----------------
  logic       c_start = 1'b0;
  logic [7:0] c_stim, c_ref, c_dut;
  logic       c_valid, c_busy, c_done, c_pass;
  logic [15:0] c_err, c_first;
  logic [1:0] c_dbg;
  logic [7:0] c_p1;
  logic       c_v1;
  int         c_cnt, c_i1;
  bit         c_bad [16];

  always @(posedge clk) begin
    if (rst || c_start) c_cnt <= 0;
    else if (c_valid) c_cnt <= c_cnt + 1;
    c_p1 <= c_stim; c_v1 <= c_valid; c_i1 <= c_cnt;
  end
  assign c_ref = ex_f(c_p1);
  assign c_dut = c_ref ^ ((c_v1 && c_bad[c_i1 & 15]) ? 8'h01 : 8'h00);

  exercise_stim_chk #(.DATA_W(8), .OUT_W(8), .NUM_VECTORS(16), .DUT_LAT(1)) u_c (
    .clk(clk), .reset(rst), .start(c_start), .stim(c_stim), .stim_valid(c_valid),
    .dut_out(c_dut), .ref_out(c_ref), .busy(c_busy), .done(c_done), .pass(c_pass),
    .err_cnt(c_err), .first_err_idx(c_first), .dbg_state(c_dbg));

  // ------- instance B: 65535 vectors, combinational, seed 0, always wrong -------
  logic       b_start = 1'b0;
  logic [7:0] b_stim, b_ref, b_dut;
  logic       b_valid, b_busy, b_done, b_pass;
  logic [15:0] b_err, b_first;
  logic [1:0] b_dbg;
  assign b_ref = ex_f(b_stim);
  assign b_dut = ~b_ref;

  exercise_stim_chk #(.DATA_W(8), .OUT_W(8), .NUM_VECTORS(65535), .DUT_LAT(0),
                      .LFSR_SEED(16'h0000)) u_b (
    .clk(clk), .reset(rst), .start(b_start), .stim(b_stim), .stim_valid(b_valid),
    .dut_out(b_dut), .ref_out(b_ref), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_cnt(b_err), .first_err_idx(b_first), .dbg_state(b_dbg));

  // ---------------- scoreboard queues ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic build_exp(input logic [15:0] seed, input int n);
    logic [15:0] s;
    s = seed;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(s[7:0]);
      s = lfsr_adv(s);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulses start on A, collects every valid stim and returns the cycle count
  // (after the start edge) at which done is first seen; -1 if never.
  task automatic run_a(output int done_cyc);
    got_q.delete();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    done_cyc = -1;
    for (int c = 0; c <= 60; c++) begin
      if (a_valid) got_q.push_back(a_stim);
      if (a_done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_c(output int done_cyc);
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    done_cyc = -1;
    for (int c = 0; c <= 60; c++) begin
      if (c_done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_stim !== 8'h00) begin n_fail++; $display("FAIL reset_stim: got %h expected 00", a_stim); end
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    n_cmp++; if ({a_busy, a_done, a_pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {a_busy, a_done, a_pass}); end
    n_cmp++; if (a_err !== 16'h0000) begin n_fail++; $display("FAIL reset_err: got %h expected 0000", a_err); end
    n_cmp++; if (a_first !== 16'hFFFF) begin n_fail++; $display("FAIL reset_first: got %h expected ffff", a_first); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stim_sequence();
    int dc;
    foreach (a_bad[i]) a_bad[i] = 1'b0;
    build_exp(16'hACE1, 16);
    run_a(dc);
    n_cmp++; if (got_q.size() != 16) begin n_fail++; $display("FAIL valid_count: got %0d expected 16", got_q.size()); end
    n_cmp++; if (got_q.size() < 2 || got_q[0] !== 8'hE1 || got_q[1] !== 8'hC3) begin
      n_fail++; $display("FAIL first_two_stim: got %p expected E1 C3", got_q); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stim_vec%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (dc != 18) begin n_fail++; $display("FAIL done_latency: got %0d expected 18", dc); end
    n_cmp++; if (a_pass !== 1'b1 || a_err !== 16'h0 || a_first !== 16'hFFFF) begin
      n_fail++; $display("FAIL clean_result: got pass=%b err=%h first=%h expected 1/0000/ffff", a_pass, a_err, a_first); end
    n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b expected 0", a_busy); end
  endtask

  task automatic test_random_errors();
    int dc, n, first, exp_n, exp_dc;
    repeat (5) begin
      n = 0; first = 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
        a_bad[i] = ($urandom_range(0, 3) == 0);
        if (a_bad[i]) begin
          n++;
          if (first == 16'hFFFF) first = i;
        end
      end
      exp_n  = ERR_STOP ? ((n > 0) ? 1 : 0) : n;
      exp_dc = (ERR_STOP && n > 0) ? first + 3 : 18;
      run_a(dc);
      n_cmp++; if (a_err !== 16'(exp_n)) begin n_fail++; $display("FAIL rnd_err_cnt: got %0d expected %0d", a_err, exp_n); end
      n_cmp++; if (a_first !== 16'(first)) begin n_fail++; $display("FAIL rnd_first_idx: got %h expected %h", a_first, 16'(first)); end
      n_cmp++; if (a_pass !== (n == 0)) begin n_fail++; $display("FAIL rnd_pass: got %b expected %b", a_pass, (n == 0)); end
      n_cmp++; if (dc != exp_dc) begin n_fail++; $display("FAIL rnd_done_latency: got %0d expected %0d", dc, exp_dc); end
    end
    foreach (a_bad[i]) a_bad[i] = 1'b0;
  endtask

  task automatic test_err_vectors();
    int dc;
    foreach (c_bad[i]) c_bad[i] = 1'b0;
    c_bad[5] = 1'b1;
    c_bad[9] = 1'b1;
    run_c(dc);
    n_cmp++; if (c_err !== (ERR_STOP ? 16'd1 : 16'd2)) begin n_fail++; $display("FAIL lat1_err_cnt: got %0d expected %0d", c_err, ERR_STOP ? 1 : 2); end
    n_cmp++; if (c_first !== 16'd5) begin n_fail++; $display("FAIL lat1_first_idx: got %0d expected 5", c_first); end
    n_cmp++; if (c_pass !== 1'b0) begin n_fail++; $display("FAIL lat1_pass: got %b expected 0", c_pass); end
    n_cmp++; if (dc != (ERR_STOP ? 7 : 17)) begin n_fail++; $display("FAIL lat1_done_latency: got %0d expected %0d", dc, ERR_STOP ? 7 : 17); end
  endtask

  task automatic test_start_ignored_reset();
    int dc;
    build_exp(16'hACE1, 16);
    got_q.delete();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      if (a_valid) got_q.push_back(a_stim);
      if (c == 7) break;
      a_start = (c == 3);
      @(posedge clk); #1;
    end
    a_start = 1'b0;
    n_cmp++; if (got_q.size() != 8) begin n_fail++; $display("FAIL ignore_valid_count: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ignore_stim_vec%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    // Reset while vector 7 is on stim.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if ({a_valid, a_busy, a_done, a_pass} !== 4'b0000 || a_stim !== 8'h00) begin
      n_fail++; $display("FAIL midrun_reset_flags: got v/b/d/p=%b stim=%h expected 0000/00", {a_valid, a_busy, a_done, a_pass}, a_stim); end
    n_cmp++; if (a_err !== 16'h0 || a_first !== 16'hFFFF) begin
      n_fail++; $display("FAIL midrun_reset_counts: got err=%h first=%h expected 0000/ffff", a_err, a_first); end
    @(posedge clk); #1;
    run_a(dc);
    n_cmp++; if (got_q.size() == 0 || got_q[0] !== 8'hE1) begin n_fail++; $display("FAIL restart_seed: got %p expected E1 first", got_q); end
    n_cmp++; if (dc != 18 || a_pass !== 1'b1) begin n_fail++; $display("FAIL restart_result: got done=%0d pass=%b expected 18/1", dc, a_pass); end
  endtask

  task automatic test_saturation();
    int dc;
    logic [7:0] first_stim;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    first_stim = b_stim;
    n_cmp++; if (b_valid !== 1'b1 || first_stim !== 8'h01) begin
      n_fail++; $display("FAIL zero_seed_stim: got valid=%b stim=%h expected 1/01", b_valid, first_stim); end
    dc = -1;
    for (int c = 0; c <= 70000; c++) begin
      if (b_done) begin
        dc = c;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (dc != (ERR_STOP ? 1 : 65536)) begin n_fail++; $display("FAIL sat_done_latency: got %0d expected %0d", dc, ERR_STOP ? 1 : 65536); end
    n_cmp++; if (b_err !== (ERR_STOP ? 16'h0001 : 16'hFFFF)) begin n_fail++; $display("FAIL sat_err_cnt: got %h expected %h", b_err, ERR_STOP ? 16'h0001 : 16'hFFFF); end
    n_cmp++; if (b_first !== 16'h0000 || b_pass !== 1'b0) begin
      n_fail++; $display("FAIL sat_first_pass: got first=%h pass=%b expected 0000/0", b_first, b_pass); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    foreach (a_bad[i]) a_bad[i] = 1'b0;
    foreach (c_bad[i]) c_bad[i] = 1'b0;
    test_reset();
    test_stim_sequence();
    test_random_errors();
    test_err_vectors();
    test_start_ignored_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exercise_stim_chk.md
# exercise_stim_chk

Self-checking stimulus/response stage for the basic-character exercise top: generates pseudo-random input vectors for the selected exercise module, collects its outputs alongside a golden reference, and reports mismatch count, first failing vector and a pass flag. It sits directly upstream (stimulus) and downstream (checking) of the exercise top, giving every `ifdef`-selected exercise one on-board regression harness.

## Interface
- `DATA_W`, 8: stimulus width (1..16), taken from LFSR low bits.
- `OUT_W`, 8: width of the exercise output and reference output.
- `NUM_VECTORS`, 256: vectors per run (1..65535).
- `DUT_LAT`, 0: clock cycles from `stim` to aligned `dut_out`/`ref_out` (0..3; 0 = combinational exercise).
- `LFSR_SEED`, 16'hACE1: LFSR load value at run start; 0 is forced to 16'h0001.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle run request.
- `stim` out DATA_W: registered stimulus to the exercise.
- `stim_valid` out 1: `stim` holds a new vector this cycle.
- `dut_out` in OUT_W: exercise output, DUT_LAT-aligned.
- `ref_out` in OUT_W: golden output, same alignment.
- `busy` out 1: run or drain in progress.
- `done` out 1: run complete, results stable.
- `pass` out 1: valid while `done`; 1 iff `err_cnt`==0.
- `err_cnt` out 16: mismatches, saturating at 16'hFFFF.
- `first_err_idx` out 16: index of first mismatching vector; 16'hFFFF if none.

## Operation
- FSM: IDLE, RUN, DRAIN, DONE. Reset -> IDLE; all outputs 0 except `first_err_idx`=16'hFFFF; LFSR = seed.
- IDLE: `start` -> RUN; load LFSR, clear `vec_idx`, `err_cnt`, `first_err_idx`.
- RUN: `stim_valid`=1 every cycle; `stim`=LFSR[DATA_W-1:0]; LFSR steps every cycle. Feedback = q15^q13^q12^q10; next = {q[14:0],fb}. After vector NUM_VECTORS-1 is issued -> DRAIN.
- DRAIN: `stim_valid`=0, `stim` holds; wait DUT_LAT cycles for the compare pipe to empty (DUT_LAT=0: one cycle), then -> DONE.
- DONE: `done`=1, `pass` valid; hold until `start`, which restarts as in IDLE (results cleared).
- Compare: valid pipe of depth DUT_LAT with vector index. When delayed valid is high and `dut_out`!=`ref_out`: `err_cnt`++ (saturating); if first mismatch of run, `first_err_idx` = that vector's index.
- `start` ignored in RUN/DRAIN. `reset` mid-run aborts immediately to reset state; pipe flushed, no compare on the following cycle.
- `busy` = RUN or DRAIN.

## Timing
- `start` sampled at edge N -> `stim_valid`=1 and first vector (seed low bits) from cycle N+1.
- Vector k driven in cycle N+1+k; compared in cycle N+1+k+DUT_LAT; counters update on the next edge.
- `done` rises exactly NUM_VECTORS+max(DUT_LAT,1) cycles after `start` is sampled.
- `err_cnt`/`first_err_idx` stable and final by the cycle `done` rises.

## Configuration
- `EXERCISE_STIM_CHK_ERR_STOP_EN`: defined -> first mismatch forces RUN/DRAIN -> DONE on the next edge (`stim_valid` drops, in-flight compares discarded, `err_cnt`=1, `pass`=0). Undefined -> full run always completes and counts every mismatch.

## Test plan
- Reset, then `start`, DATA_W=8, default seed -> `stim`=8'hE1 then 8'hC3 on first two valid cycles; `stim_valid` high exactly NUM_VECTORS cycles.
- `ref_out` tied to `dut_out`, NUM_VECTORS=16, DUT_LAT=2 -> `done` 18 cycles after `start`, `pass`=1, `err_cnt`=0, `first_err_idx`=16'hFFFF.
- `dut_out` corrupted on vectors 5 and 9, DUT_LAT=1 -> `err_cnt`=2, `first_err_idx`=5, `pass`=0 (with ERR_STOP_EN: `err_cnt`=1, `done` one cycle after vector 5 compare).
- `dut_out`=~`ref_out` always, NUM_VECTORS=65535 -> `err_cnt`=16'hFFFF, no wrap.
- `start` pulsed during RUN -> ignored; `reset` at vector 7 -> all outputs at reset values next cycle; fresh `start` restarts with seed vector.
- LFSR_SEED=0 -> first 16-bit state 16'h0001, `stim`=8'h01.
